// File: rtl/stage_writeback.sv
// Write-back stage: a one-entry WB pipeline register feeding a 31x32 register
// file, combinational read ports with WB bypass, retired-instruction counting
// and a sticky halt raised by retiring the halt instruction.
module stage_writeback #(
   parameter int          INSTRET_W = 64,
   parameter logic [31:0] HALT_IR   = 32'h00100073
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 ma_valid_i,
   input  logic [31:0]          ma_ir_i,
   input  logic                 ma_wb_en_i,
   input  logic [4:0]           ma_wb_addr_i,
   input  logic [31:0]          ma_wb_data_i,
   input  logic [4:0]           id_rs1_addr_i,
   input  logic [4:0]           id_rs2_addr_i,
   output logic [31:0]          id_rs1_data_o,
   output logic [31:0]          id_rs2_data_o,
   output logic [4:0]           hz_wb_addr_o,
   output logic [31:0]          hz_wb_data_o,
   output logic                 hz_wb_valid_o,
   output logic [INSTRET_W-1:0] wb_instret_o,
   output logic                 wb_halt_o
);

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regaddr_t;

   typedef struct packed {
      logic     valid;
      word_t    ir;
      logic     wb_en;
      regaddr_t addr;
      word_t    data;
   } wb_entry_t;

   wb_entry_t pipe;
   word_t     rf [0:31];
   logic      is_halt;
   logic      write_active;

   // WB pipeline register: no backpressure, every cycle's input is taken
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) pipe <= '0;
      else          pipe <= '{valid: ma_valid_i, ir: ma_ir_i, wb_en: ma_wb_en_i,
                              addr: ma_wb_addr_i, data: ma_wb_data_i};
   end

   // A retiring halt never writes, even with wb_en set; nothing writes once halted
   always_comb begin
      is_halt      = pipe.valid && (pipe.ir == HALT_IR);
      write_active = pipe.valid && pipe.wb_en && (pipe.addr != '0) && !wb_halt_o && !is_halt;
   end

   // Forwarding bus is zeroed when the entry will not commit
   always_comb begin
      hz_wb_valid_o = write_active;
      hz_wb_addr_o  = write_active ? pipe.addr : '0;
      hz_wb_data_o  = write_active ? pipe.data : '0;
   end

   // Register file: x0 has no storage and reads as zero
   for (genvar r = 0; r < 32; r++) begin : g_rf
      if (r == 0) begin : g_x0
         assign rf[r] = '0;
      end else begin : g_xn
         // Commit the WB entry one edge after capture
         always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i)                                     rf[r] <= '0;
            else if (write_active && (pipe.addr == 5'(r)))    rf[r] <= pipe.data;
         end
      end
   end

   // Read ports: the pending WB entry is newer than the file, so it wins
   always_comb begin
      id_rs1_data_o = rf[id_rs1_addr_i];
      id_rs2_data_o = rf[id_rs2_addr_i];
      if (hz_wb_valid_o && (id_rs1_addr_i == hz_wb_addr_o)) id_rs1_data_o = hz_wb_data_o;
      if (hz_wb_valid_o && (id_rs2_addr_i == hz_wb_addr_o)) id_rs2_data_o = hz_wb_data_o;
   end

   // Retire count and sticky halt; the halt instruction itself is counted
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wb_instret_o <= '0;
         wb_halt_o    <= 1'b0;
      end else if (pipe.valid && !wb_halt_o) begin
         wb_instret_o <= wb_instret_o + 1'b1;
         if (is_halt) wb_halt_o <= 1'b1;
      end
   end

endmodule
